// File: rtl/ifetch_stage.sv
// ifetch_stage: instruction-fetch stage of the MIPS pipeline.
// Holds the PC, drives the word address into a combinational-read
// instruction memory and captures the returned word into the IF/ID
// register. A taken redirect squashes the word fetched in the same cycle,
// so there is no delay slot.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [6:0]  imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_plus4;
  logic [31:0] br_aligned;

  // The low two target bits are masked rather than trapped on.
  assign br_aligned = br_target & 32'hFFFF_FFFC;
  assign pc_plus4   = pc + 32'd4;
  assign imem_addr  = pc[8:2];

  // Redirect beats stall beats flush; only a plain fetch captures a real word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      if_instr    <= NOP_INSTR;
      if_pc       <= 32'h0000_0000;
      if_pc4      <= 32'h0000_0000;
      if_valid    <= 1'b0;
      fetch_count <= 32'h0000_0000;
    end else if (br_taken) begin
      pc       <= br_aligned;
      if_instr <= NOP_INSTR;
      if_valid <= 1'b0;
    end else if (stall && flush) begin
      if_instr <= NOP_INSTR;
      if_valid <= 1'b0;
    end else if (stall) begin
      pc       <= pc;
      if_valid <= if_valid;
    end else if (flush) begin
      pc       <= pc_plus4;
      if_instr <= NOP_INSTR;
      if_valid <= 1'b0;
    end else begin
      pc          <= pc_plus4;
      if_instr    <= imem_data;
      if_pc       <= pc;
      if_pc4      <= pc_plus4;
      if_valid    <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: self-checking bench for ifetch_stage with directed
// scenarios and a randomized run against a behavioural model.
module tb_ifetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  imem_addr;
  logic [31:0] imem_data;
  logic        stall, flush, br_taken;
  logic [31:0] br_target;
  logic [31:0] pc, if_instr, if_pc, if_pc4, fetch_count;
  logic        if_valid;

  logic [31:0] mem [0:127];

  int checks = 0;
  int errors = 0;

  // Behavioural model of the fetch stage's architectural state
  logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4, m_count;
  logic        m_valid;

  // Free-running clock
  always #5 clk = ~clk;

  // Combinational-read instruction memory
  assign imem_data = mem[imem_addr];

  ifetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .flush(flush), .br_taken(br_taken), .br_target(br_target),
    .pc(pc), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4),
    .if_valid(if_valid), .fetch_count(fetch_count)
  );

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_ifpc = 32'h0; m_ifpc4 = 32'h0;
    m_valid = 1'b0; m_count = 32'h0;
  endtask

  // One edge of the specified priority rules, applied to the model
  task automatic model_step(input logic st, input logic fl, input logic bt,
                            input logic [31:0] tgt);
    if (bt) begin
      m_pc = tgt & ~32'd3; m_instr = NOP; m_valid = 1'b0;
    end else if (st && fl) begin
      m_instr = NOP; m_valid = 1'b0;
    end else if (st) begin
      m_valid = m_valid;
    end else if (fl) begin
      m_pc = m_pc + 4; m_instr = NOP; m_valid = 1'b0;
    end else begin
      m_instr = mem[m_pc[8:2]]; m_ifpc = m_pc; m_ifpc4 = m_pc + 4;
      m_valid = 1'b1; m_count = m_count + 1; m_pc = m_pc + 4;
    end
  endtask

  // Drive inputs, advance one edge and settle; the model follows along
  task automatic drive_edge(input logic st, input logic fl, input logic bt,
                            input logic [31:0] tgt);
    stall = st; flush = fl; br_taken = bt; br_target = tgt;
    model_step(st, fl, bt, tgt);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stall = 0; flush = 0; br_taken = 0; br_target = 32'h0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 128; k++) mem[k] = 32'h1000_0000 + k;
  endtask

  task automatic test_reset();
    load_ramp();
    do_reset();
    checks++;
    if (pc !== 32'h0 || if_instr !== NOP || if_pc !== 32'h0 || if_pc4 !== 32'h0 ||
        if_valid !== 1'b0 || fetch_count !== 32'h0 || imem_addr !== 7'd0) begin
      errors++;
      $display("[TB] FAIL reset_state pc=%h instr=%h ifpc=%h ifpc4=%h valid=%b cnt=%0d addr=%0d, want all zero",
               pc, if_instr, if_pc, if_pc4, if_valid, fetch_count, imem_addr);
    end
  endtask

  task automatic test_free_run();
    load_ramp();
    do_reset();
    for (int n = 0; n < 8; n++) begin
      drive_edge(0, 0, 0, 32'h0);
      checks++;
      if (if_instr !== 32'h1000_0000 + n || if_pc !== 4 * n || if_pc4 !== 4 * n + 4 ||
          if_valid !== 1'b1 || fetch_count !== n + 1 || pc !== 4 * n + 4 ||
          imem_addr !== 7'(n + 1)) begin
        errors++;
        $display("[TB] FAIL free_run n=%0d instr=%h ifpc=%h ifpc4=%h valid=%b cnt=%0d pc=%h addr=%0d",
                 n, if_instr, if_pc, if_pc4, if_valid, fetch_count, pc, imem_addr);
      end
    end
  endtask

  task automatic test_stall();
    load_ramp();
    do_reset();
    drive_edge(0, 0, 0, 32'h0);
    drive_edge(0, 0, 0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      drive_edge(1, 0, 0, 32'h0);
      checks++;
      if (pc !== 32'h8 || imem_addr !== 7'd2 || if_instr !== 32'h1000_0001 ||
          if_pc !== 32'h4 || if_valid !== 1'b1 || fetch_count !== 32'd2) begin
        errors++;
        $display("[TB] FAIL stall_hold c=%0d pc=%h addr=%0d instr=%h ifpc=%h valid=%b cnt=%0d (want 8,2,10000001,4,1,2)",
                 c, pc, imem_addr, if_instr, if_pc, if_valid, fetch_count);
      end
    end
    drive_edge(0, 0, 0, 32'h0);
    checks++;
    if (if_instr !== 32'h1000_0002 || if_pc !== 32'h8 || fetch_count !== 32'd3 || pc !== 32'hC) begin
      errors++;
      $display("[TB] FAIL stall_release instr=%h ifpc=%h cnt=%0d pc=%h (want 10000002,8,3,c)",
               if_instr, if_pc, fetch_count, pc);
    end
  endtask

  task automatic test_branch();
    load_ramp();
    do_reset();
    for (int c = 0; c < 3; c++) drive_edge(0, 0, 0, 32'h0);
    drive_edge(0, 0, 1, 32'h0000_0043);
    checks++;
    if (pc !== 32'h40 || if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 32'h8 ||
        if_pc4 !== 32'hC || fetch_count !== 32'd3) begin
      errors++;
      $display("[TB] FAIL branch_bubble pc=%h valid=%b instr=%h ifpc=%h ifpc4=%h cnt=%0d (want 40,0,0,8,c,3)",
               pc, if_valid, if_instr, if_pc, if_pc4, fetch_count);
    end
    drive_edge(0, 0, 0, 32'h0);
    checks++;
    if (if_instr !== 32'h1000_0010 || if_pc !== 32'h40 || if_pc4 !== 32'h44 || if_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL branch_target instr=%h ifpc=%h ifpc4=%h valid=%b (want 10000010,40,44,1)",
               if_instr, if_pc, if_pc4, if_valid);
    end
  endtask

  task automatic test_priority();
    load_ramp();
    do_reset();
    drive_edge(0, 0, 0, 32'h0);
    drive_edge(1, 0, 1, 32'h0000_0020);
    checks++;
    if (pc !== 32'h20 || if_valid !== 1'b0 || if_instr !== NOP || fetch_count !== 32'd1) begin
      errors++;
      $display("[TB] FAIL br_over_stall pc=%h valid=%b instr=%h cnt=%0d (want 20,0,0,1)",
               pc, if_valid, if_instr, fetch_count);
    end
    drive_edge(0, 0, 0, 32'h0);
    drive_edge(1, 1, 0, 32'h0);
    checks++;
    if (pc !== 32'h24 || if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 32'h20 || fetch_count !== 32'd2) begin
      errors++;
      $display("[TB] FAIL stall_flush pc=%h valid=%b instr=%h ifpc=%h cnt=%0d (want 24,0,0,20,2)",
               pc, if_valid, if_instr, if_pc, fetch_count);
    end
    drive_edge(0, 1, 0, 32'h0);
    checks++;
    if (pc !== 32'h28 || if_valid !== 1'b0 || if_instr !== NOP || fetch_count !== 32'd2) begin
      errors++;
      $display("[TB] FAIL flush_only pc=%h valid=%b instr=%h cnt=%0d (want 28,0,0,2)",
               pc, if_valid, if_instr, fetch_count);
    end
  endtask

  task automatic test_wrap();
    load_ramp();
    do_reset();
    drive_edge(0, 0, 1, 32'h0000_01F8);
    checks++;
    if (imem_addr !== 7'd126) begin
      errors++;
      $display("[TB] FAIL wrap_addr126 addr=%0d want 126", imem_addr);
    end
    drive_edge(0, 0, 0, 32'h0);
    checks++;
    if (imem_addr !== 7'd127 || if_instr !== 32'h1000_007E) begin
      errors++;
      $display("[TB] FAIL wrap_addr127 addr=%0d instr=%h (want 127,1000007e)", imem_addr, if_instr);
    end
    drive_edge(0, 0, 0, 32'h0);
    checks++;
    if (imem_addr !== 7'd0 || pc !== 32'h200 || if_instr !== 32'h1000_007F) begin
      errors++;
      $display("[TB] FAIL wrap_addr0 addr=%0d pc=%h instr=%h (want 0,200,1000007f)", imem_addr, pc, if_instr);
    end
    drive_edge(0, 0, 0, 32'h0);
    checks++;
    if (if_pc !== 32'h200 || if_instr !== 32'h1000_0000 || if_pc4 !== 32'h204) begin
      errors++;
      $display("[TB] FAIL wrap_mem0 ifpc=%h instr=%h ifpc4=%h (want 200,10000000,204)", if_pc, if_instr, if_pc4);
    end
  endtask

  task automatic test_async_reset();
    load_ramp();
    do_reset();
    for (int c = 0; c < 8; c++) drive_edge(0, 0, 0, 32'h0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (pc !== 32'h0 || if_instr !== NOP || if_pc !== 32'h0 || if_pc4 !== 32'h0 ||
        if_valid !== 1'b0 || fetch_count !== 32'h0 || imem_addr !== 7'd0) begin
      errors++;
      $display("[TB] FAIL async_reset pc=%h instr=%h ifpc=%h ifpc4=%h valid=%b cnt=%0d addr=%0d, want all zero",
               pc, if_instr, if_pc, if_pc4, if_valid, fetch_count, imem_addr);
    end
    #2;
    rst_n = 1'b1;
    drive_edge(0, 0, 0, 32'h0);
    checks++;
    if (pc !== 32'h4 || if_instr !== 32'h1000_0000 || if_valid !== 1'b1 || fetch_count !== 32'd1) begin
      errors++;
      $display("[TB] FAIL async_resume pc=%h instr=%h valid=%b cnt=%0d (want 4,10000000,1,1)",
               pc, if_instr, if_valid, fetch_count);
    end
  endtask

  task automatic test_random();
    logic st, fl, bt;
    logic [31:0] tgt;
    for (int k = 0; k < 128; k++) mem[k] = $urandom;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 4) == 0);
      bt  = ($urandom_range(0, 7) == 0);
      tgt = $urandom;
      drive_edge(st, fl, bt, tgt);
      checks++;
      if (pc !== m_pc || if_instr !== m_instr || if_pc !== m_ifpc || if_pc4 !== m_ifpc4 ||
          if_valid !== m_valid || fetch_count !== m_count || imem_addr !== m_pc[8:2]) begin
        errors++;
        $display("[TB] FAIL random c=%0d pc=%h/%h instr=%h/%h ifpc=%h/%h ifpc4=%h/%h valid=%b/%b cnt=%0d/%0d (got/want)",
                 c, pc, m_pc, if_instr, m_instr, if_pc, m_ifpc, if_pc4, m_ifpc4,
                 if_valid, m_valid, fetch_count, m_count);
      end
    end
  endtask

  // Scenario sequence
  initial begin
    rst_n = 1'b0;
    stall = 0; flush = 0; br_taken = 0; br_target = 32'h0;
    test_reset();
    test_free_run();
    test_stall();
    test_branch();
    test_priority();
    test_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction-fetch stage for the MIPS pipeline. Holds the program counter, drives the word address into instruction memory (combinational read, 128 x 32-bit), and captures the returned instruction into the IF/ID pipeline register. Accepts stall and flush from the hazard unit and branch/jump redirects from the ID/EX stage. No delay slot: a taken redirect squashes the instruction fetched in the same cycle.

## Interface
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset; bits [1:0] must be 0
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on bubble/squash
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  7  word address to instruction memory, = pc[8:2]
- imem_data  in  32  instruction word from instruction memory, valid same cycle
- stall  in  1  hold PC and IF/ID contents
- flush  in  1  replace next IF/ID contents with bubble
- br_taken  in  1  redirect PC to br_target this cycle
- br_target  in  32  redirect byte address; bits [1:0] ignored (treated as 00)
- pc  out  32  current fetch PC
- if_instr  out  32  IF/ID instruction
- if_pc  out  32  IF/ID byte address of if_instr
- if_pc4  out  32  IF/ID if_pc + 4
- if_valid  out  1  IF/ID holds a real instruction
- fetch_count  out  32  number of instructions captured with if_valid=1

## Operation
- Reset (rst_n=0, asynchronous): pc=RESET_PC, if_instr=NOP_INSTR, if_pc=0, if_pc4=0, if_valid=0, fetch_count=0. Reset asserted mid-operation discards all state immediately.
- imem_addr is purely combinational from pc[8:2]; no registered address.
- Per rising edge, priority high to low:
  - br_taken=1: pc <= {br_target[31:2],2'b00}; IF/ID <= bubble. Overrides stall and flush.
  - stall=1 and flush=1: pc holds; IF/ID <= bubble.
  - stall=1: pc holds; IF/ID holds (including if_valid).
  - flush=1: pc <= pc+4; IF/ID <= bubble.
  - otherwise: pc <= pc+4; if_instr <= imem_data, if_pc <= pc, if_pc4 <= pc+4, if_valid <= 1.
- Bubble: if_instr=NOP_INSTR, if_valid=0, if_pc and if_pc4 hold their previous values.
- fetch_count increments by 1 on each edge where a real capture occurs (last case only); wraps modulo 2^32.
- Arithmetic: pc+4 is 32-bit, wraps at 2^32 with no flag. The 512-byte window of imem wraps naturally because only pc[8:2] is used, e.g. pc=32'h0000_01FC -> 32'h0000_0200 gives imem_addr 127 -> 0.
- br_target with nonzero bits [1:0] is silently aligned; no exception is generated.

## Timing
- Fetch latency: the instruction at pc appears on if_instr one edge after pc is presented.
- Redirect penalty: 1 bubble. On a redirect edge, the wrong-path word is dropped; the target instruction is captured on the following edge.
- Stall: zero-cycle response; pc, imem_addr, and IF/ID are frozen at the edge where stall=1 is sampled.
- First valid instruction after reset release: captured at the first rising edge with rst_n=1, provided no stall, flush, or redirect is active.
- All outputs except imem_addr are registered; imem_addr changes only after pc changes.

## Test plan
- Reset then free run with MEM[k]=32'h1000_0000+k: pc steps 0,4,8,...; edge n gives if_instr=32'h1000_0000+n, if_pc=4n, if_valid=1, and fetch_count=n+1.
- Stall for 3 cycles at pc=8: pc stays 8 and IF/ID holds the word from MEM[1] with if_valid=1; after release, MEM[2] is captured and fetch_count has no extra increments.
- br_taken with br_target=32'h0000_0043 while pc=12: next pc=32'h40, IF/ID becomes a bubble (if_valid=0, if_instr=NOP_INSTR), then MEM[16] is captured with if_pc=32'h40.
- br_taken and stall in the same cycle: the redirect wins, pc=br_target, and a bubble is inserted. stall and flush together: pc holds and a bubble is inserted.
- Wrap: free run from pc=32'h1F8 gives imem_addr 126, 127, then 0, with if_pc=32'h200 for MEM[0].
- Assert rst_n=0 asynchronously mid-cycle at pc=32'h20: all outputs go to their reset values before the next edge; fetch resumes from RESET_PC after release.
